// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_rem, r_q, r_d;
  logic [CW-1:0] r_cnt;
  logic [WIDTH:0] w_shift;
  logic [WIDTH-1:0] w_rem_next, w_q_next;
  logic w_borrow, w_accept, w_last, w_zero;
  assign in_ready = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign w_accept = in_valid && in_ready;
  assign w_zero = divisor == '0;
  assign w_last = r_cnt == LAST;
  // The stored remainder is always below the divisor, so only the shifted value needs WIDTH+1 bits
  // and the low WIDTH bits of the difference are exact whenever there is no borrow.
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_borrow = w_shift < {1'b0, r_d};
  assign w_rem_next = w_borrow ? w_shift[WIDTH-1:0] : w_shift[WIDTH-1:0] - r_d;
  assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};
  // State register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  // Next-state logic: zero divisor skips the iterations entirely
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_accept ? (w_zero ? DONE : CALC) : IDLE;
      CALC: w_next = w_last ? DONE : CALC;
      DONE: w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // Datapath: load on accept, iterate MSB first in CALC, publish results on the last iteration
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rem <= '0;
      r_q <= '0;
      r_d <= '0;
      r_cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_rem <= '0;
      r_q <= dividend;
      r_d <= divisor;
      r_cnt <= '0;
      if (w_zero) begin
        quotient <= '1;
        remainder <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_rem_next;
      r_q <= w_q_next;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        quotient <= w_q_next;
        remainder <= w_rem_next;
        div_by_zero <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: randomized self-checking bench against a plain / and % model
module tb_seq_restoring_divider;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic div_by_zero;
  int n_cmp = 0;
  int n_err = 0;

  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_q(input logic [7:0] a, input logic [7:0] b);
    return (b == 0) ? 8'hFF : 8'(int'(a) / int'(b));
  endfunction

  function automatic logic [7:0] exp_r(input logic [7:0] a, input logic [7:0] b);
    return (b == 0) ? a : 8'(int'(a) % int'(b));
  endfunction

  // Runs one operation; lat counts edges from the accepting edge (1) to the first valid sample.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int stall,
                       output logic [7:0] q, output logic [7:0] r, output logic z,
                       output int lat, output bit held);
    @(negedge clk);
    dividend = a;
    divisor = b;
    in_valid = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor = 8'($urandom);
    lat = 1;
    held = 1'b1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      lat++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || in_ready || quotient !== q || remainder !== r || div_by_zero !== z) held = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++;
    if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got q=%0d r=%0d z=%b expected 0 0 0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_basic;
    logic [7:0] q, r;
    logic z;
    int lat;
    bit held;
    do_op(8'd100, 8'd7, 0, q, r, z, lat, held);
    n_cmp++;
    if (q !== 8'd14 || r !== 8'd2 || z !== 1'b0) begin
      n_err++;
      $display("FAIL basic_100_7: got q=%0d r=%0d z=%b expected 14 2 0", q, r, z);
    end
    n_cmp++;
    if (lat !== 9) begin n_err++; $display("FAIL basic_latency: got %0d expected 9", lat); end
  endtask

  task automatic test_boundaries;
    logic [7:0] as [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
    logic [7:0] bs [4] = '{8'd1, 8'd9, 8'd255, 8'd13};
    logic [7:0] qs [4] = '{8'd255, 8'd0, 8'd1, 8'd0};
    logic [7:0] rs [4] = '{8'd0, 8'd5, 8'd0, 8'd0};
    logic [7:0] q, r;
    logic z;
    int lat;
    bit held;
    for (int k = 0; k < 4; k++) begin
      do_op(as[k], bs[k], 0, q, r, z, lat, held);
      n_cmp++;
      if (q !== qs[k] || r !== rs[k] || z !== 1'b0 || lat !== 9) begin
        n_err++;
        $display("FAIL boundary_%0d_%0d: got q=%0d r=%0d z=%b lat=%0d expected %0d %0d 0 9",
                 as[k], bs[k], q, r, z, lat, qs[k], rs[k]);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [7:0] q, r;
    logic z;
    int lat;
    bit held;
    do_op(8'd37, 8'd0, 0, q, r, z, lat, held);
    n_cmp++;
    if (q !== 8'd255 || r !== 8'd37 || z !== 1'b1) begin
      n_err++;
      $display("FAIL div_zero_result: got q=%0d r=%0d z=%b expected 255 37 1", q, r, z);
    end
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL div_zero_latency: got %0d expected 1", lat); end
    do_op(8'd9, 8'd4, 0, q, r, z, lat, held);
    n_cmp++;
    if (q !== 8'd2 || r !== 8'd1 || z !== 1'b0) begin
      n_err++;
      $display("FAIL dbz_clears: got q=%0d r=%0d z=%b expected 2 1 0", q, r, z);
    end
  endtask

  task automatic test_back_pressure;
    int lat = 0;
    bit bad = 1'b0;
    @(negedge clk);
    dividend = 8'd200;
    divisor = 8'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (!out_valid) begin n_err++; $display("FAIL bp_timeout: got out_valid=0 expected 1"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1)) | (i == 0);
      dividend = 8'd10;
      divisor = 8'd2;
      if (!out_valid || in_ready !== 1'b0 || quotient !== 8'd66 || remainder !== 8'd2 || div_by_zero !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL bp_hold: got q=%0d r=%0d ov=%b ir=%b expected 66 2 1 0", quotient, remainder, out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got ov=%b ir=%b expected 0 1", out_valid, in_ready);
    end
    n_cmp++;
    if (quotient !== 8'd66 || remainder !== 8'd2) begin
      n_err++;
      $display("FAIL bp_retain: got q=%0d r=%0d expected 66 2", quotient, remainder);
    end
  endtask

  task automatic test_reset_abort;
    logic [7:0] q, r;
    logic z;
    int lat;
    bit held;
    bit seen = 1'b0;
    @(negedge clk);
    dividend = 8'd123;
    divisor = 8'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL abort_clear: got ov=%b q=%0d r=%0d z=%b expected 0 0 0 0", out_valid, quotient, remainder, div_by_zero);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL abort_no_result: got out_valid=1 expected 0"); end
    do_op(8'd50, 8'd6, 0, q, r, z, lat, held);
    n_cmp++;
    if (q !== 8'd8 || r !== 8'd2 || z !== 1'b0 || lat !== 9) begin
      n_err++;
      $display("FAIL abort_next_op: got q=%0d r=%0d z=%b lat=%0d expected 8 2 0 9", q, r, z, lat);
    end
  endtask

  task automatic test_random;
    logic [7:0] a, b, q, r;
    logic z;
    int lat;
    bit held;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      do_op(a, b, int'($urandom_range(0, 3)), q, r, z, lat, held);
      n_cmp++;
      if (q !== exp_q(a, b) || r !== exp_r(a, b) || z !== (b == 0)) begin
        n_err++;
        $display("FAIL rand_%0d_%0d: got q=%0d r=%0d z=%b expected %0d %0d %b",
                 a, b, q, r, z, exp_q(a, b), exp_r(a, b), b == 0);
      end
      n_cmp++;
      if (lat !== ((b == 0) ? 1 : 9)) begin
        n_err++;
        $display("FAIL rand_latency_%0d_%0d: got %0d expected %0d", a, b, lat, (b == 0) ? 1 : 9);
      end
      n_cmp++;
      if (!held) begin n_err++; $display("FAIL rand_hold_%0d_%0d: got unstable result expected stable", a, b); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_back_pressure();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
